// File: rtl/commit_monitor.sv
// Commit monitor: shadow GPR file, last-DEPTH commit trace ring and the
// ebreak/timeout halt state machine, all driven from one commit interface.
module commit_monitor #(
  parameter int XLEN         = 64,
  parameter int NR_REG       = 32,
  parameter int DEPTH        = 16,
  parameter int TIMEOUT      = 1024,
  parameter int DRAIN_CYCLES = 4,
  parameter int AW           = $clog2(NR_REG),
  parameter int TW           = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit_valid,
  input  logic [XLEN-1:0] commit_pc,
  input  logic [31:0]     commit_inst,
  input  logic            commit_wen,
  input  logic [AW-1:0]   commit_waddr,
  input  logic [XLEN-1:0] commit_wdata,
  input  logic            is_break,
  input  logic [AW-1:0]   gpr_rd_idx,
  output logic [XLEN-1:0] gpr_rd_data,
  input  logic [TW-1:0]   trace_rd_idx,
  output logic            trace_rd_valid,
  output logic [XLEN-1:0] trace_rd_pc,
  output logic [31:0]     trace_rd_inst,
  output logic [TW:0]     trace_count,
  output logic [63:0]     commit_count,
  output logic [1:0]      state,
  output logic            halt,
  output logic [1:0]      halt_code,
  output logic            late_commit
);

  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam int DW = $clog2(DRAIN_CYCLES) + 1;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DRAIN  = 2'b01,
    HALTED = 2'b10
  } state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   gpr_q [NR_REG];
  logic [XLEN-1:0]   gpr_d [NR_REG];
  logic [XLEN-1:0]   trace_pc_q [DEPTH];
  logic [XLEN-1:0]   trace_pc_d [DEPTH];
  logic [31:0]       trace_inst_q [DEPTH];
  logic [31:0]       trace_inst_d [DEPTH];
  logic [TW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [TW:0]       trace_count_q, trace_count_d;
  logic [63:0]       commit_count_q, commit_count_d;
  logic [WW-1:0]     wdog_q, wdog_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [1:0]        halt_code_q, halt_code_d;
  logic              late_q, late_d;
  logic              accept_s;
  logic [XLEN-1:0]   a0_s;
  logic [TW-1:0]     rd_ptr_s;

  // Datapath next state: shadow GPRs, trace ring, counters.
  always_comb begin
    accept_s       = commit_valid && (state_q == RUN);
    gpr_d          = gpr_q;
    trace_pc_d     = trace_pc_q;
    trace_inst_d   = trace_inst_q;
    wr_ptr_d       = wr_ptr_q;
    trace_count_d  = trace_count_q;
    commit_count_d = commit_count_q;
    if (accept_s) begin
      if (commit_wen && (commit_waddr != {AW{1'b0}})) begin
        gpr_d[commit_waddr] = commit_wdata;
      end else begin
        gpr_d = gpr_q;
      end
      trace_pc_d[wr_ptr_q]   = commit_pc;
      trace_inst_d[wr_ptr_q] = commit_inst;
      wr_ptr_d               = wr_ptr_q + TW'(1'b1);
      commit_count_d         = commit_count_q + 64'd1;
      if (trace_count_q != (TW+1)'(DEPTH)) begin
        trace_count_d = trace_count_q + (TW+1)'(1'b1);
      end else begin
        trace_count_d = trace_count_q;
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
  end

  // Halt FSM: watchdog, ebreak decode with a0 forwarding, drain counter.
  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    drain_d     = drain_q;
    halt_code_d = halt_code_q;
    late_d      = late_q | (commit_valid && (state_q != RUN));
    if (commit_wen && (commit_waddr == AW'(5'd10))) begin
      a0_s = commit_wdata;
    end else begin
      a0_s = gpr_q[10];
    end
    case (state_q)
      RUN: begin
        if (accept_s) begin
          wdog_d = {WW{1'b0}};
          if (is_break) begin
            state_d     = DRAIN;
            drain_d     = {DW{1'b0}};
            halt_code_d = (a0_s == {XLEN{1'b0}}) ? 2'b01 : 2'b10;
          end else begin
            state_d = RUN;
          end
        end else if (wdog_q == WW'(TIMEOUT - 1)) begin
          state_d     = DRAIN;
          drain_d     = {DW{1'b0}};
          halt_code_d = 2'b11;
        end else begin
          wdog_d = wdog_q + WW'(1'b1);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          state_d = HALTED;
        end else begin
          drain_d = drain_q + DW'(1'b1);
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      gpr_q          <= '{default: '0};
      trace_pc_q     <= '{default: '0};
      trace_inst_q   <= '{default: '0};
      wr_ptr_q       <= {TW{1'b0}};
      trace_count_q  <= {(TW+1){1'b0}};
      commit_count_q <= 64'd0;
      wdog_q         <= {WW{1'b0}};
      drain_q        <= {DW{1'b0}};
      halt_code_q    <= 2'b00;
      late_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      gpr_q          <= gpr_d;
      trace_pc_q     <= trace_pc_d;
      trace_inst_q   <= trace_inst_d;
      wr_ptr_q       <= wr_ptr_d;
      trace_count_q  <= trace_count_d;
      commit_count_q <= commit_count_d;
      wdog_q         <= wdog_d;
      drain_q        <= drain_d;
      halt_code_q    <= halt_code_d;
      late_q         <= late_d;
    end
  end

  // Read ports: age index 0 is the entry just behind the write pointer.
  always_comb begin
    rd_ptr_s       = wr_ptr_q - TW'(1'b1) - trace_rd_idx;
    trace_rd_valid = ({1'b0, trace_rd_idx} < trace_count_q);
    if (trace_rd_valid) begin
      trace_rd_pc   = trace_pc_q[rd_ptr_s];
      trace_rd_inst = trace_inst_q[rd_ptr_s];
    end else begin
      trace_rd_pc   = {XLEN{1'b0}};
      trace_rd_inst = 32'd0;
    end
    if (gpr_rd_idx == {AW{1'b0}}) begin
      gpr_rd_data = {XLEN{1'b0}};
    end else begin
      gpr_rd_data = gpr_q[gpr_rd_idx];
    end
  end

  assign trace_count  = trace_count_q;
  assign commit_count = commit_count_q;
  assign state        = state_q;
  assign halt         = (state_q == HALTED);
  assign halt_code    = halt_code_q;
  assign late_commit  = late_q;

endmodule

// File: doc/commit_monitor.md
Name: commit_monitor

Overview:
Simulation-side commit monitor for the NPC core. It generalises the fixed 32-port register snapshot into a sequential block that does three things from a single commit interface: it keeps a shadow GPR file, records the last DEPTH commits in a ring buffer (itrace), and runs the ebreak/timeout halt state machine. Sits beside the core top. Feeds the DPI/difftest layer and the testbench through read ports and halt status.

Parameters:
XLEN, 64, GPR and PC width
NR_REG, 32, number of GPRs (power of 2; index width AW = log2(NR_REG))
DEPTH, 16, trace ring entries (power of 2, >= 2)
TIMEOUT, 1024, consecutive no-commit cycles in RUN that trigger a timeout halt
DRAIN_CYCLES, 4, cycles spent in DRAIN before HALTED

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
commit_valid  in  1  one instruction retires this cycle
commit_pc  in  XLEN  PC of the retiring instruction
commit_inst  in  32  instruction word
commit_wen  in  1  retiring instruction writes a GPR
commit_waddr  in  AW  destination register
commit_wdata  in  XLEN  write-back data
is_break  in  1  retiring instruction is ebreak; qualified by commit_valid
gpr_rd_idx  in  AW  shadow GPR read index
gpr_rd_data  out  XLEN  shadow GPR value, combinational
trace_rd_idx  in  log2(DEPTH)  trace age index; 0 = most recent
trace_rd_valid  out  1  entry exists
trace_rd_pc  out  XLEN  traced PC
trace_rd_inst  out  32  traced instruction
trace_count  out  log2(DEPTH)+1  valid entries, saturates at DEPTH
commit_count  out  64  total accepted commits
state  out  2  00 RUN, 01 DRAIN, 10 HALTED
halt  out  1  high in HALTED
halt_code  out  2  00 none, 01 good trap, 10 bad trap, 11 timeout
late_commit  out  1  sticky; a commit arrived while not in RUN

Behaviour:
- Reset (sync, rst=1 at posedge): all shadow GPRs=0, ring pointer=0, trace_count=0, commit_count=0, watchdog=0, drain counter=0, state=RUN, halt=0, halt_code=00, late_commit=0. A reset in any state, including DRAIN or HALTED, returns the block to RUN on the next edge.
- Accepted commit: commit_valid=1 and state=RUN.
- Shadow GPR update:
  - On an accepted commit with commit_wen=1 and commit_waddr!=0, shadow[waddr] takes wdata at the edge.
  - gpr_rd_data reflects the update one cycle later (no bypass).
  - Index 0 always reads 0.
- Trace ring:
  - Each accepted commit writes {pc, inst} at the write pointer.
  - The write pointer increments mod DEPTH, so the oldest entry is overwritten on wrap.
  - trace_count increments, saturating at DEPTH.
  - Read entry = (wr_ptr-1-trace_rd_idx) mod DEPTH.
  - trace_rd_valid = (trace_rd_idx < trace_count). When invalid, pc and inst read 0.
- commit_count: increments by 1 per accepted commit; 64-bit wrap.
- Watchdog:
  - In RUN, an accepted commit clears it to 0; otherwise it increments.
  - When it equals TIMEOUT-1 and no commit arrives that cycle, the next edge moves to DRAIN with halt_code=11.
  - Frozen outside RUN.
- Ebreak:
  - An accepted commit with is_break=1 moves to DRAIN at the edge; the commit itself is still traced and counted.
  - a0 = x10, with forwarding: if the same commit writes x10, use commit_wdata, else use shadow[10].
  - halt_code = 01 if a0==0, else 10.
  - Ebreak wins over a same-cycle timeout, because the commit clears the watchdog.
- DRAIN: counts DRAIN_CYCLES edges, then moves to HALTED. halt_code is held.
- HALTED: absorbing until rst; halt=1.
- Commits outside RUN: ignored (no GPR, trace or count update) and set late_commit=1.
- halt_code changes only on the RUN->DRAIN transition and on reset.

Test Plan:
1. Reset, then commits write x5=0x1234 and x0=0xFF -> gpr[5]=0x1234 one cycle later, gpr[0]=0, commit_count=2.
2. 20 commits with pc=0x80000000+4k, k=0..19, DEPTH=16 -> trace_count=16; idx0 pc=0x8000004C; idx15 pc=0x80000010.
3. x10=0, then ebreak commit -> DRAIN next cycle, HALTED after 4 cycles, halt=1, halt_code=01, commit_count includes the ebreak.
4. Ebreak commit that itself writes x10=7 -> halt_code=10 (forwarded value used).
5. No commits for 1024 cycles after reset -> DRAIN at cycle 1024, halt_code=11. A commit at cycle 1023 instead -> stays RUN.
6. Commit in HALTED -> late_commit=1, counts unchanged. Then rst=1 for one cycle -> state=RUN, all outputs at reset values.
